// File: rtl/lesson_ctrl.sv
// Lesson-mode sequencer: walks the player through the stored phrase one note at a time,
// drives hint LEDs / expected-note code and counts wrong presses and timeouts.
module lesson_ctrl #(
  parameter int SONG_LEN      = 15,
  parameter int TIMEOUT_BEATS = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       start,
  input  logic       beat,
  input  logic [3:0] play_note,
  output logic [3:0] expect_note,
  output logic [7:0] Led,
  output logic [4:0] step,
  output logic [7:0] mistakes,
  output logic       busy,
  output logic       done
);

  localparam int TW = ($clog2(TIMEOUT_BEATS) > 4) ? $clog2(TIMEOUT_BEATS) : 4;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WAIT_PRESS   = 3'd1,
    WAIT_RELEASE = 3'd2,
    ERROR_HOLD   = 3'd3,
    DONE         = 3'd4
  } state_t;

  function automatic logic [3:0] song_rom(input logic [4:0] idx);
    case (idx)
      5'd0:    song_rom = 4'd3;
      5'd1:    song_rom = 4'd3;
      5'd2:    song_rom = 4'd4;
      5'd3:    song_rom = 4'd5;
      5'd4:    song_rom = 4'd5;
      5'd5:    song_rom = 4'd4;
      5'd6:    song_rom = 4'd3;
      5'd7:    song_rom = 4'd2;
      5'd8:    song_rom = 4'd1;
      5'd9:    song_rom = 4'd1;
      5'd10:   song_rom = 4'd2;
      5'd11:   song_rom = 4'd3;
      5'd12:   song_rom = 4'd3;
      5'd13:   song_rom = 4'd2;
      5'd14:   song_rom = 4'd2;
      default: song_rom = 4'd0;
    endcase
  endfunction

  // C4 lights bit 7, C5 lights bit 0; error and finished states light everything.
  function automatic logic [7:0] led_of(input state_t st, input logic [3:0] code);
    case (st)
      IDLE:             led_of = 8'h00;
      ERROR_HOLD, DONE: led_of = 8'hFF;
      default:          led_of = (code == 4'd0) ? 8'h00 : (8'h80 >> (code - 4'd1));
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  state_t         state_q, state_d;
  logic [4:0]     step_q, step_d;
  logic [7:0]     mistakes_q, mistakes_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [3:0]     expect_q;
  logic [7:0]     led_q;
  logic           busy_q, done_q;
  logic [3:0]     cur_note_s;
  logic           last_step_s;

  assign cur_note_s  = song_rom(step_q);
  assign last_step_s = (step_q == 5'(SONG_LEN - 1));

  // Next-state logic; start overrides whatever the current state would do.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    mistakes_d = mistakes_q;
    timer_d    = timer_q;
    if (start) begin
      state_d    = WAIT_PRESS;
      step_d     = 5'd0;
      mistakes_d = 8'd0;
      timer_d    = '0;
    end else begin
      case (state_q)
        WAIT_PRESS: begin
          if (play_note == 4'd0) begin
            if (beat) begin
              if (timer_q == TW'(TIMEOUT_BEATS - 1)) begin
                mistakes_d = sat_inc(mistakes_q);
                timer_d    = '0;
              end else begin
                timer_d = timer_q + TW'(1);
              end
            end else begin
              timer_d = timer_q;
            end
          end else if (play_note == cur_note_s) begin
            state_d = WAIT_RELEASE;
            timer_d = '0;
          end else begin
            state_d    = ERROR_HOLD;
            mistakes_d = sat_inc(mistakes_q);
            timer_d    = '0;
          end
        end
        WAIT_RELEASE: begin
          if (play_note == 4'd0) begin
            if (last_step_s) begin
              state_d = DONE;
            end else begin
              state_d = WAIT_PRESS;
              step_d  = step_q + 5'd1;
              timer_d = '0;
            end
          end else begin
            state_d = WAIT_RELEASE;
          end
        end
        ERROR_HOLD: begin
          if (play_note == 4'd0) begin
            state_d = WAIT_PRESS;
            timer_d = '0;
          end else begin
            state_d = ERROR_HOLD;
          end
        end
        IDLE:    state_d = IDLE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers; outputs are registered from the next-state values so they
  // line up with the registered state one cycle after the sampling edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      step_q     <= 5'd0;
      mistakes_q <= 8'd0;
      timer_q    <= '0;
      expect_q   <= 4'd0;
      led_q      <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      mistakes_q <= mistakes_d;
      timer_q    <= timer_d;
      expect_q   <= (state_d == IDLE) ? 4'd0 : song_rom(step_d);
      led_q      <= led_of(state_d, song_rom(step_d));
      busy_q     <= (state_d == WAIT_PRESS) || (state_d == WAIT_RELEASE) ||
                    (state_d == ERROR_HOLD);
      done_q     <= (state_d == DONE);
    end
  end

  assign expect_note = expect_q;
  assign Led         = led_q;
  assign step        = step_q;
  assign mistakes    = mistakes_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_lesson_ctrl.sv
// Directed bench for lesson_ctrl: reset, clean run, repeat guard, wrong note,
// timeout, saturation, restart and reset-with-start.
module tb_lesson_ctrl;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       start = 1'b0;
  logic       beat = 1'b0;
  logic [3:0] play_note = 4'd0;
  logic [3:0] expect_note;
  logic [7:0] Led;
  logic [4:0] step;
  logic [7:0] mistakes;
  logic       busy;
  logic       done;

  int tests_run = 0;
  int tests_failed = 0;

  logic [3:0] song [15] = '{4'd3, 4'd3, 4'd4, 4'd5, 4'd5, 4'd4, 4'd3, 4'd2,
                            4'd1, 4'd1, 4'd2, 4'd3, 4'd3, 4'd2, 4'd2};

  lesson_ctrl #(.SONG_LEN(15), .TIMEOUT_BEATS(8)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .beat(beat), .play_note(play_note),
    .expect_note(expect_note), .Led(Led), .step(step), .mistakes(mistakes),
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic press(input logic [3:0] code);
    play_note = code;
    tick(2);
    play_note = 4'd0;
    tick(2);
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick(2);
    RESET = 1'b0;
    tick(10);
    tests_run++; if (expect_note !== 4'd0) begin tests_failed++; $display("FAIL reset_expect got %0d want 0", expect_note); end
    tests_run++; if (Led !== 8'h00) begin tests_failed++; $display("FAIL reset_led got %h want 00", Led); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", done); end
    tests_run++; if (mistakes !== 8'd0) begin tests_failed++; $display("FAIL reset_mistakes got %0d want 0", mistakes); end
    tests_run++; if (step !== 5'd0) begin tests_failed++; $display("FAIL reset_step got %0d want 0", step); end
  endtask

  task automatic test_clean_run();
    logic [7:0] exp_led;
    pulse_start();
    tests_run++; if (Led !== 8'b0010_0000) begin tests_failed++; $display("FAIL clean_led0 got %b want 00100000", Led); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL clean_busy got %b want 1", busy); end
    for (int i = 0; i < 15; i++) begin
      exp_led = 8'h80 >> (song[i] - 4'd1);
      tests_run++; if (step !== 5'(i)) begin tests_failed++; $display("FAIL clean_step got %0d want %0d", step, i); end
      tests_run++; if (expect_note !== song[i]) begin tests_failed++; $display("FAIL clean_expect step %0d got %0d want %0d", i, expect_note, song[i]); end
      play_note = song[i];
      tick(3);
      tests_run++; if (Led !== exp_led || step !== 5'(i)) begin tests_failed++; $display("FAIL clean_held step %0d got led %h step %0d want led %h", i, Led, step, exp_led); end
      play_note = 4'd0;
      tick(3);
    end
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL clean_done got %b want 1", done); end
    tests_run++; if (Led !== 8'hFF) begin tests_failed++; $display("FAIL clean_done_led got %h want FF", Led); end
    tests_run++; if (step !== 5'd14) begin tests_failed++; $display("FAIL clean_done_step got %0d want 14", step); end
    tests_run++; if (mistakes !== 8'd0) begin tests_failed++; $display("FAIL clean_mistakes got %0d want 0", mistakes); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL clean_done_busy got %b want 0", busy); end
  endtask

  task automatic test_repeat_guard();
    pulse_start();
    tests_run++; if (step !== 5'd0 || busy !== 1'b1 || done !== 1'b0) begin tests_failed++; $display("FAIL restart_from_done got step %0d busy %b done %b want 0 1 0", step, busy, done); end
    play_note = 4'd3;
    tick(20);
    tests_run++; if (step !== 5'd0) begin tests_failed++; $display("FAIL repeat_hold_step got %0d want 0", step); end
    play_note = 4'd0;
    tick(1);
    tests_run++; if (step !== 5'd1) begin tests_failed++; $display("FAIL repeat_release_step got %0d want 1", step); end
    tests_run++; if (expect_note !== 4'd3) begin tests_failed++; $display("FAIL repeat_expect got %0d want 3", expect_note); end
  endtask

  task automatic test_wrong_note();
    pulse_start();
    press(4'd3);
    press(4'd3);
    tests_run++; if (step !== 5'd2 || expect_note !== 4'd4) begin tests_failed++; $display("FAIL wrong_setup got step %0d expect %0d want 2 4", step, expect_note); end
    play_note = 4'd7;
    tick(2);
    tests_run++; if (mistakes !== 8'd1) begin tests_failed++; $display("FAIL wrong_mistakes1 got %0d want 1", mistakes); end
    tests_run++; if (Led !== 8'hFF) begin tests_failed++; $display("FAIL wrong_led got %h want FF", Led); end
    play_note = 4'd2;
    tick(2);
    tests_run++; if (mistakes !== 8'd1) begin tests_failed++; $display("FAIL wrong_second_note got %0d want 1", mistakes); end
    play_note = 4'd0;
    tick(1);
    tests_run++; if (step !== 5'd2 || expect_note !== 4'd4) begin tests_failed++; $display("FAIL wrong_return got step %0d expect %0d want 2 4", step, expect_note); end
    tests_run++; if (Led !== 8'h10) begin tests_failed++; $display("FAIL wrong_return_led got %h want 10", Led); end
  endtask

  task automatic test_timeout();
    pulse_start();
    play_note = 4'd0;
    for (int b = 0; b < 7; b++) begin
      beat = 1'b1;
      tick(1);
      beat = 1'b0;
      tick(1);
    end
    tests_run++; if (mistakes !== 8'd0) begin tests_failed++; $display("FAIL timeout_7beats got %0d want 0", mistakes); end
    beat = 1'b1;
    tick(1);
    beat = 1'b0;
    tests_run++; if (mistakes !== 8'd1) begin tests_failed++; $display("FAIL timeout_8th got %0d want 1", mistakes); end
    tests_run++; if (step !== 5'd0) begin tests_failed++; $display("FAIL timeout_step got %0d want 0", step); end
    tick(1);
    // a press coinciding with the 8th beat of the next window must win
    for (int b = 0; b < 7; b++) begin
      beat = 1'b1;
      tick(1);
      beat = 1'b0;
      tick(1);
    end
    beat = 1'b1;
    play_note = 4'd3;
    tick(1);
    beat = 1'b0;
    tests_run++; if (mistakes !== 8'd1) begin tests_failed++; $display("FAIL timeout_press_wins got %0d want 1", mistakes); end
    play_note = 4'd0;
    tick(1);
    tests_run++; if (step !== 5'd1) begin tests_failed++; $display("FAIL timeout_press_step got %0d want 1", step); end
  endtask

  task automatic test_saturation();
    pulse_start();
    for (int k = 0; k < 255; k++) begin
      play_note = 4'd7;
      tick(1);
      play_note = 4'd0;
      tick(1);
    end
    tests_run++; if (mistakes !== 8'd255) begin tests_failed++; $display("FAIL sat_255 got %0d want 255", mistakes); end
    play_note = 4'd7;
    tick(1);
    play_note = 4'd0;
    tick(1);
    tests_run++; if (mistakes !== 8'd255) begin tests_failed++; $display("FAIL sat_256 got %0d want 255", mistakes); end
  endtask

  task automatic test_restart_reset();
    pulse_start();
    press(4'd6);
    for (int i = 0; i < 6; i++) press(song[i]);
    tests_run++; if (step !== 5'd6 || mistakes !== 8'd1) begin tests_failed++; $display("FAIL restart_setup got step %0d mistakes %0d want 6 1", step, mistakes); end
    pulse_start();
    tests_run++; if (step !== 5'd0 || mistakes !== 8'd0) begin tests_failed++; $display("FAIL restart_clear got step %0d mistakes %0d want 0 0", step, mistakes); end
    tests_run++; if (busy !== 1'b1 || Led !== 8'h20) begin tests_failed++; $display("FAIL restart_wait_press got busy %b led %h want 1 20", busy, Led); end
    for (int i = 0; i < 4; i++) press(song[i]);
    tests_run++; if (step !== 5'd4) begin tests_failed++; $display("FAIL reset_setup_step got %0d want 4", step); end
    RESET = 1'b1;
    start = 1'b1;
    tick(1);
    RESET = 1'b0;
    start = 1'b0;
    tests_run++; if (step !== 5'd0 || mistakes !== 8'd0) begin tests_failed++; $display("FAIL reset_start_regs got step %0d mistakes %0d want 0 0", step, mistakes); end
    tests_run++; if (expect_note !== 4'd0 || Led !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL reset_start_outs got expect %0d led %h busy %b done %b want 0 00 0 0", expect_note, Led, busy, done); end
    play_note = 4'd3;
    tick(3);
    play_note = 4'd0;
    tick(1);
    tests_run++; if (busy !== 1'b0 || step !== 5'd0 || mistakes !== 8'd0) begin tests_failed++; $display("FAIL reset_stays_idle got busy %b step %0d mistakes %0d want 0 0 0", busy, step, mistakes); end
  endtask

  initial begin
    tick(1);
    test_reset();
    test_clean_run();
    test_repeat_guard();
    test_wrong_note();
    test_timeout();
    test_saturation();
    test_restart_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
